// File: rtl/tree_route_input_ctrl.sv
// tree_route_input_ctrl: buffered input port of a radix-2^RADIX_LOG2 tree router.
// Routes each head packet up or to one child, drops U-turns, counts forwarded/dropped.
module tree_route_input_ctrl #(
  parameter int PKT_W       = 14,
  parameter int ADDR_W      = 3,
  parameter int DEST_W      = 3,
  parameter int RADIX_LOG2  = 1,
  parameter int LEVEL       = 0,
  parameter int NODE_PREFIX = 0,
  parameter int IN_PORT     = 0,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  localparam int NUM_OUT    = (1 << RADIX_LOG2) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PKT_W-1:0]   in_data,
  output logic               out_valid,
  output logic [NUM_OUT-1:0] out_sel,
  output logic [PKT_W-1:0]   out_data,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [CNT_W-1:0]   fwd_count,
  output logic [CNT_W-1:0]   drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(NUM_OUT);
  localparam int DM = PKT_W - ADDR_W - 1;
  localparam int PW = (LEVEL == 0) ? 1 : LEVEL * RADIX_LOG2;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic rdy_q, ov_q, ov_d;
  logic [NUM_OUT-1:0] sel_q, sel_d;
  logic [PKT_W-1:0] data_q, data_d, head;
  logic [CNT_W-1:0] fwd_q, fwd_d, drop_q, drop_d;
  logic [TW-1:0] target;
  logic push, empty, full, fire, uturn, drop, load;
  assign head = mem[rd_q[AW-1:0]];
  generate
    if (LEVEL == 0) begin : g_root
      assign target = TW'(head[DM -: RADIX_LOG2]) + TW'(1);
    end else begin : g_inner
      assign target = (head[DM -: PW] == NODE_PREFIX[PW-1:0])
                    ? TW'(head[DM-PW -: RADIX_LOG2]) + TW'(1) : '0;
    end
  endgenerate
  assign empty    = wr_q == rd_q;
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // rdy_q keeps in_ready low throughout reset and opens it on the first edge after release
  assign in_ready = rdy_q & !full;
  assign push     = in_valid & in_ready;
  assign uturn    = target == TW'(IN_PORT);
  assign fire     = ov_q & |(sel_q & out_ready);
  assign drop     = !empty & uturn;
  assign load     = !empty & !uturn & (!ov_q | fire);
  always_comb begin
    wr_d   = wr_q + (AW+1)'(push);
    rd_d   = rd_q + (AW+1)'(drop | load);
    ov_d   = load | (ov_q & !fire);
    sel_d  = load ? NUM_OUT'(1) << target : sel_q;
    data_d = load ? head : data_q;
    fwd_d  = (fire && fwd_q != '1) ? fwd_q + CNT_W'(1) : fwd_q;
    drop_d = (drop && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
  end
  always_ff @(posedge clk) if (push) mem[wr_q[AW-1:0]] <= in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      rdy_q  <= 1'b0;
      ov_q   <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
      fwd_q  <= '0;
      drop_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      rdy_q  <= 1'b1;
      ov_q   <= ov_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      fwd_q  <= fwd_d;
      drop_q <= drop_d;
    end
  assign out_valid  = ov_q;
  assign out_sel    = sel_q;
  assign out_data   = data_q;
  assign fwd_count  = fwd_q;
  assign drop_count = drop_q;
endmodule
